// File: rtl/fixed_point_add_sequencer_if.sv
// Valid/ready bundle between a wide-operand requester and the add sequencer.
//   req_valid/req_ready : request handshake, requester -> sequencer
//   req_a/req_b         : W-bit operands, W = N*K
//   req_ci/req_sub      : carry (borrow) in, subtract select
//   rsp_valid/rsp_ready : response handshake, sequencer -> consumer
//   rsp_sum/rsp_co/rsp_ovf : W-bit result, carry out, signed overflow
// master = requester/consumer side, slave = sequencer side.
interface fixed_point_add_sequencer_if #(
    parameter int N = 32,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_ci;
    logic         req_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_co;
    logic         rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_ci, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ci, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ovf
    );
endinterface

// File: rtl/fixed_point_add_sequencer.sv
// Wide (N*K-bit) adder built from one shared N-bit adder slice, stepped
// over K cycles with the carry chained through a register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fixed_point_add_sequencer_if.slave (request/response handshakes)
// Optional feature: define ADD_SEQ_SUB_EN to honour req_sub (A + ~B + ~ci).
// Without it req_sub is ignored and no inversion logic is built.
module fixed_point_add_sequencer #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fixed_point_add_sequencer_if.slave    bus
);
    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IW-1:0]        r_idx;
    logic [K-1:0][N-1:0]  r_a;
    logic [K-1:0][N-1:0]  r_b;
    logic [K-1:0][N-1:0]  r_sum;
    logic                 r_carry;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic                 r_co;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic [N-1:0]         w_slice_sum;
    logic                 w_slice_co;
    logic [W-1:0]         w_b_in;
    logic                 w_ci_in;

`ifdef ADD_SEQ_SUB_EN
    // Subtraction as A + ~B + ~ci, so carry out = 1 means no borrow.
    assign w_b_in  = bus.req_sub ? ~bus.req_b : bus.req_b;
    assign w_ci_in = bus.req_ci ^ bus.req_sub;
`else
    assign w_b_in  = bus.req_b;
    assign w_ci_in = bus.req_ci;
`endif

    assign w_accept = (r_state == IDLE) && r_req_ready && bus.req_valid;
    assign w_last   = (r_idx == LAST_IDX);

    // The one shared slice adder.
    assign {w_slice_co, w_slice_sum} = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx]}
                                     + {{N{1'b0}}, r_carry};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_sum       <= '0;
            r_co        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Raises req_ready on the first edge out of reset too.
                    r_req_ready <= !w_accept;
                    if (w_accept) begin
                        r_carry <= w_ci_in;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= w_slice_sum;
                    r_carry      <= w_slice_co;
                    if (w_last) begin
                        r_co        <= w_slice_co;
                        // Sign of the result comes straight from this slice.
                        r_ovf       <= (r_a[K-1][N-1] == r_b[K-1][N-1]) &&
                                       (w_slice_sum[N-1] != r_a[K-1][N-1]);
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand registers need no reset: only read after an accept loads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.req_a;
            r_b <= w_b_in;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_co    = r_co;
    assign bus.rsp_ovf   = r_ovf;
endmodule

// File: tb/tb_fixed_point_add_sequencer.sv
module tb_fixed_point_add_sequencer;
    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fixed_point_add_sequencer_if #(.N(N), .K(K)) bus();

    fixed_point_add_sequencer #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } res_t;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    // Reference: whole-word arithmetic on a W+1-bit accumulator.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub);
        res_t r;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        bb = b;
        cc = ci;
`ifdef ADD_SEQ_SUB_EN
        if (sub) begin
            bb = ~b;
            cc = ~ci;
        end
`endif
        full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        r.sum = full[W-1:0];
        r.co  = full[W];
        r.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All tasks start and end at posedge+#1.
    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sub);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready before accept", W'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_ci    = ci;
        bus.req_sub   = sub;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        // Scramble the inputs: only the accept edge may sample them.
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_ci    = 1'($urandom);
        bus.req_sub   = 1'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 50);
    endtask

    task automatic handshake(input string name);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({name, " rsp_valid drop"}, W'(bus.rsp_valid), 0);
        chk({name, " req_ready back"}, W'(bus.req_ready), 1);
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sub, input logic [W-1:0] esum,
                           input logic eco, input logic eovf, input int hold);
        int lat;
        send_req(a, b, ci, sub);
        wait_rsp(lat);
        chk({name, " latency"}, W'(lat), 4);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        chk({name, " sum"}, bus.rsp_sum, esum);
        chk({name, " co"},  W'(bus.rsp_co),  W'(eco));
        chk({name, " ovf"}, W'(bus.rsp_ovf), W'(eovf));
        handshake(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        logic [W-1:0] s0;
        logic         c0, o0;
        res_t         r;
        logic [W-1:0] corner[6];
        logic [W-1:0] a, b;
        logic         ci, sub;

        vecs[0] = '{"wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{"ovf",       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{"xslice",    32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
`ifdef ADD_SEQ_SUB_EN
        vecs[3] = '{"sub",       32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
`else
        vecs[3] = '{"sub",       32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0};
`endif
        vecs[4] = '{"negovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{"cin_chain", 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        vecs[6] = '{"small",     32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0};

        corner = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                   32'h8000_0000, 32'h00FF_00FF, 32'hFF00_FF00};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ci    = 1'b0;
        bus.req_sub   = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset req_ready", W'(bus.req_ready), 0);
        chk("reset rsp_valid", W'(bus.rsp_valid), 0);
        chk("reset rsp_sum",   bus.rsp_sum, 0);
        chk("reset rsp_co",    W'(bus.rsp_co), 0);
        chk("reset rsp_ovf",   W'(bus.rsp_ovf), 0);
        rst_n = 1'b1;
        #1;
        chk("req_ready low right after release", W'(bus.req_ready), 0);
        @(posedge clk); #1;
        chk("req_ready one edge after release", W'(bus.req_ready), 1);

        // Directed table
        foreach (vecs[i])
            run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
                    vecs[i].sum, vecs[i].co, vecs[i].ovf, 0);

        // rsp_ready already high when rsp_valid rises
        bus.rsp_ready = 1'b1;
        send_req(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
        wait_rsp(lat);
        chk("early_ready latency", W'(lat), 4);
        chk("early_ready sum", bus.rsp_sum, 32'h0000_1234);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("early_ready rsp_valid drop", W'(bus.rsp_valid), 0);
        chk("early_ready req_ready back", W'(bus.req_ready), 1);

        // Backpressure with a competing request held on the bus
        r = model(32'h1234_5678, 32'h89AB_CDEF, 1'b1, 1'b0);
        send_req(32'h1234_5678, 32'h89AB_CDEF, 1'b1, 1'b0);
        wait_rsp(lat);
        chk("bp latency", W'(lat), 4);
        chk("bp sum", bus.rsp_sum, r.sum);
        chk("bp co",  W'(bus.rsp_co), W'(r.co));
        s0 = bus.rsp_sum;
        c0 = bus.rsp_co;
        o0 = bus.rsp_ovf;
        bus.req_valid = 1'b1;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp sum hold",       bus.rsp_sum, s0);
            chk("bp co hold",        W'(bus.rsp_co), W'(c0));
            chk("bp ovf hold",       W'(bus.rsp_ovf), W'(o0));
            chk("bp rsp_valid hold", W'(bus.rsp_valid), 1);
            chk("bp req_ready low",  W'(bus.req_ready), 0);
        end
        bus.req_valid = 1'b0;
        handshake("bp");
        run_vec("bp second", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0100, 1'b0, 1'b0, 0);

        // Reset during the second RUN cycle
        send_req(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst req_ready", W'(bus.req_ready), 0);
        chk("midrst rsp_valid", W'(bus.rsp_valid), 0);
        chk("midrst rsp_sum",   bus.rsp_sum, 0);
        chk("midrst rsp_co",    W'(bus.rsp_co), 0);
        chk("midrst rsp_ovf",   W'(bus.rsp_ovf), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst req_ready after release", W'(bus.req_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst no stale rsp", W'(bus.rsp_valid), 0);
        end
        run_vec("post reset", 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0,
                32'h0000_0008, 1'b0, 1'b0, 0);

        // Randomized against the reference model
        for (int i = 0; i < 150; i++) begin
            a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            ci  = 1'($urandom);
            sub = 1'($urandom);
            r   = model(a, b, ci, sub);
            run_vec("rand", a, b, ci, sub, r.sum, r.co, r.ovf, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
